// File: rtl/spi_slave_byte_rx_pkg.sv
// Shared defaults and state encoding for the SPI slave receive path.
// Also used by the downstream word splitter and its TX counterpart.
package spi_slave_byte_rx_pkg;

  localparam int SPI_DATA_WIDTH_DEF = 8;
  localparam int SYNC_STAGES_DEF    = 2;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_slave_byte_rx_sync_edge.sv
// 1-bit synchroniser plus registered rise/fall detector.
// Latency: level after SYNC_STAGES clk, edge flags one clk later; no backpressure.
module spi_slave_byte_rx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_byte_rx.sv
// SPI mode-0 slave receiver: spi_ready/from_spi SYNC_STAGES+2 clk after the completing sclk rise.
// No backpressure (consumer must take every strobe); SPI_SLAVE_TX_EN adds the MISO reply shifter.
module spi_slave_byte_rx
  import spi_slave_byte_rx_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      mosi,
  input  logic                      cs_n,
  output logic                      miso,
  input  logic [SPI_DATA_WIDTH-1:0] tx_data,
  output logic                      tx_load,
  output logic                      spi_ready,
  output logic [SPI_DATA_WIDTH-1:0] from_spi,
  output logic                      spi_abort,
  output logic                      busy
);

  localparam int CW = $clog2(SPI_DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(SPI_DATA_WIDTH - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s, sclk_r;

  spi_slave_byte_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .din(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_slave_byte_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst(rst), .din(cs_n), .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_chain <= '0;
    else      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // An edge only counts if the level still holds a clk later (rejects 1-clk glitches).
  assign sclk_r = sclk_rise & sclk_s;

  spi_state_t                state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [SPI_DATA_WIDTH-1:0] shift_rx, shift_nxt;
  logic                      word_done, abort_nxt, frame_start;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_nxt   = shift_rx;
    word_done   = 1'b0;
    abort_nxt   = 1'b0;
    frame_start = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_s) state_nxt = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_nxt   = SHIFT;
          cnt_nxt     = '0;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_r) begin
          shift_nxt = {shift_rx[SPI_DATA_WIDTH-2:0], mosi_s};
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            word_done = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        // Checked after the shift so a final rise coincident with cs_n rise still completes.
        if (cs_rise) begin
          state_nxt = IDLE;
          abort_nxt = (cnt_nxt != '0);
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_IDLE;
      cnt       <= '0;
      shift_rx  <= '0;
      from_spi  <= '0;
      spi_ready <= 1'b0;
      spi_abort <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shift_rx  <= shift_nxt;
      spi_ready <= word_done;
      spi_abort <= abort_nxt;
      if (word_done) from_spi <= shift_nxt;
    end
  end

  assign busy = (state == SHIFT);

`ifdef SPI_SLAVE_TX_EN
  logic [SPI_DATA_WIDTH-1:0] shift_tx;
  logic                      sclk_f;

  assign sclk_f  = sclk_fall & ~sclk_s;
  assign tx_load = frame_start | (spi_ready & (state == SHIFT));

  // The fall that ends a word (cnt back at 0) must not shift away the freshly loaded MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         shift_tx <= '0;
    else if (tx_load)                                 shift_tx <= tx_data;
    else if ((state == SHIFT) && sclk_f && cnt != '0) shift_tx <= {shift_tx[SPI_DATA_WIDTH-2:0], 1'b0};
  end

  assign miso = shift_tx[SPI_DATA_WIDTH-1];
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, sclk_fall, frame_start};
  assign tx_load   = 1'b0;
  assign miso      = 1'b0;
`endif

endmodule
